// File: rtl/trs_kbd_matrix.sv
`default_nettype none
// ============================================================================
// Module      : trs_kbd_matrix
// Description : Turns decoded PS/2 set-2 key events into the 8x8 TRS-80
//               Model I keyboard matrix. Each key is held for at least
//               HOLD_CYCLES after its latest make, so that fast taps are
//               still seen by the ROM scan loop. An F12 make raises a
//               one-cycle reset request.
// Revision    : 1.0 - initial release
// ============================================================================
module trs_kbd_matrix #(
  parameter int unsigned HOLD_CYCLES = 200000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       key_strobe,
  input  logic       key_pressed,
  input  logic       key_extended,
  input  logic [7:0] key_code,
  input  logic [7:0] cpu_addr,
  output logic [7:0] kbd_data,
  output logic       reset_req
);

  localparam int unsigned c_timer_w = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [c_timer_w-1:0] c_hold      = c_timer_w'(HOLD_CYCLES);
  localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);
  // Key slots: 8*row + bit for rows 0..6, then the two shift keys
  // (56 = left, 57 = right) which are ORed onto row 7 bit 0.
  localparam int unsigned c_slots = 58;
  localparam logic [c_slots-1:0] c_one = c_slots'(1);

  // Returns {hit, slot} for a scan code; hit = 0 for anything not in the map.
  function automatic logic [6:0] f_decode(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h054: f_decode = {1'b1, 6'd0};   // @
      9'h01C: f_decode = {1'b1, 6'd1};   // A
      9'h032: f_decode = {1'b1, 6'd2};   // B
      9'h021: f_decode = {1'b1, 6'd3};   // C
      9'h023: f_decode = {1'b1, 6'd4};   // D
      9'h024: f_decode = {1'b1, 6'd5};   // E
      9'h02B: f_decode = {1'b1, 6'd6};   // F
      9'h034: f_decode = {1'b1, 6'd7};   // G
      9'h033: f_decode = {1'b1, 6'd8};   // H
      9'h043: f_decode = {1'b1, 6'd9};   // I
      9'h03B: f_decode = {1'b1, 6'd10};  // J
      9'h042: f_decode = {1'b1, 6'd11};  // K
      9'h04B: f_decode = {1'b1, 6'd12};  // L
      9'h03A: f_decode = {1'b1, 6'd13};  // M
      9'h031: f_decode = {1'b1, 6'd14};  // N
      9'h044: f_decode = {1'b1, 6'd15};  // O
      9'h04D: f_decode = {1'b1, 6'd16};  // P
      9'h015: f_decode = {1'b1, 6'd17};  // Q
      9'h02D: f_decode = {1'b1, 6'd18};  // R
      9'h01B: f_decode = {1'b1, 6'd19};  // S
      9'h02C: f_decode = {1'b1, 6'd20};  // T
      9'h03C: f_decode = {1'b1, 6'd21};  // U
      9'h02A: f_decode = {1'b1, 6'd22};  // V
      9'h01D: f_decode = {1'b1, 6'd23};  // W
      9'h022: f_decode = {1'b1, 6'd24};  // X
      9'h035: f_decode = {1'b1, 6'd25};  // Y
      9'h01A: f_decode = {1'b1, 6'd26};  // Z
      9'h045: f_decode = {1'b1, 6'd32};  // 0
      9'h016: f_decode = {1'b1, 6'd33};  // 1
      9'h01E: f_decode = {1'b1, 6'd34};  // 2
      9'h026: f_decode = {1'b1, 6'd35};  // 3
      9'h025: f_decode = {1'b1, 6'd36};  // 4
      9'h02E: f_decode = {1'b1, 6'd37};  // 5
      9'h036: f_decode = {1'b1, 6'd38};  // 6
      9'h03D: f_decode = {1'b1, 6'd39};  // 7
      9'h03E: f_decode = {1'b1, 6'd40};  // 8
      9'h046: f_decode = {1'b1, 6'd41};  // 9
      9'h052: f_decode = {1'b1, 6'd42};  // :
      9'h04C: f_decode = {1'b1, 6'd43};  // ;
      9'h041: f_decode = {1'b1, 6'd44};  // ,
      9'h04E: f_decode = {1'b1, 6'd45};  // -
      9'h049: f_decode = {1'b1, 6'd46};  // .
      9'h04A: f_decode = {1'b1, 6'd47};  // /
      9'h05A: f_decode = {1'b1, 6'd48};  // ENTER
      9'h15A: f_decode = {1'b1, 6'd48};  // keypad ENTER
      9'h16C: f_decode = {1'b1, 6'd49};  // CLEAR (Home)
      9'h076: f_decode = {1'b1, 6'd50};  // BREAK (Esc)
      9'h175: f_decode = {1'b1, 6'd51};  // UP
      9'h172: f_decode = {1'b1, 6'd52};  // DOWN
      9'h16B: f_decode = {1'b1, 6'd53};  // LEFT
      9'h066: f_decode = {1'b1, 6'd53};  // backspace acts as LEFT
      9'h174: f_decode = {1'b1, 6'd54};  // RIGHT
      9'h029: f_decode = {1'b1, 6'd55};  // SPACE
      9'h012: f_decode = {1'b1, 6'd56};  // left shift
      9'h059: f_decode = {1'b1, 6'd57};  // right shift
      default: f_decode = 7'd0;
    endcase
  endfunction

  logic [6:0]           w_dec;
  logic                 w_is_f12;
  logic                 r_s1_valid;
  logic                 r_s1_make;
  logic                 r_s1_f12;
  logic [c_slots-1:0]   r_s1_tgt;
  logic [c_slots-1:0]   r_down;
  logic [c_slots-1:0]   r_pend;
  logic [c_timer_w-1:0] r_timer;
  logic [c_slots-1:0]   w_down_nxt;
  logic [c_slots-1:0]   w_pend_nxt;
  logic [c_timer_w-1:0] w_timer_nxt;
  logic                 w_make;
  logic                 w_break;
  logic                 w_timer_zero;
  logic [7:0]           w_sel;
  logic [7:0]           r_kbd_data;
  logic                 r_reset_req;

  assign w_dec    = f_decode(key_extended, key_code);
  assign w_is_f12 = ~key_extended & (key_code == 8'h07);

  // Stage 1: capture the event as a one-hot key target.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_make  <= 1'b0;
      r_s1_f12   <= 1'b0;
      r_s1_tgt   <= '0;
    end else begin
      r_s1_valid <= key_strobe & w_dec[6];
      r_s1_make  <= key_pressed;
      r_s1_f12   <= key_strobe & key_pressed & w_is_f12;
      r_s1_tgt   <= c_one << w_dec[5:0];
    end
  end

  assign w_make       = r_s1_valid & r_s1_make;
  assign w_break      = r_s1_valid & ~r_s1_make;
  assign w_timer_zero = (r_timer == '0);

  // Stage 2 next-state: make wins over the deferred release in the same cycle.
  always_comb begin
    w_down_nxt  = r_down;
    w_pend_nxt  = r_pend;
    w_timer_nxt = r_timer;
    if (w_make) begin
      w_timer_nxt = c_hold;
    end else if (!w_timer_zero) begin
      w_timer_nxt = r_timer - c_timer_one;
    end
    if (w_timer_zero && !w_make) begin
      w_down_nxt = r_down & ~r_pend;
      w_pend_nxt = '0;
    end
    if (w_make) begin
      w_down_nxt = w_down_nxt | r_s1_tgt;
      w_pend_nxt = w_pend_nxt & ~r_s1_tgt;
    end
    if (w_break) begin
      if (w_timer_zero) begin
        w_down_nxt = w_down_nxt & ~r_s1_tgt;
      end else begin
        // only a key that is actually down can have a deferred release
        w_pend_nxt = w_pend_nxt | (r_s1_tgt & r_down);
      end
    end
  end

  // Stage 2 state: key down/pending bits, hold timer and F12 pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_down      <= '0;
      r_pend      <= '0;
      r_timer     <= '0;
      r_reset_req <= 1'b0;
    end else begin
      r_down      <= w_down_nxt;
      r_pend      <= w_pend_nxt;
      r_timer     <= w_timer_nxt;
      r_reset_req <= r_s1_f12;
    end
  end

  // Row select: OR of every row whose address line is high. Row 3 bits 3..7
  // are never set because no scan code decodes to those slots.
  always_comb begin
    w_sel = '0;
    for (int n = 0; n < 7; n++) begin
      if (cpu_addr[n]) begin
        w_sel = w_sel | r_down[8*n +: 8];
      end
    end
    if (cpu_addr[7]) begin
      w_sel = w_sel | {7'b0, r_down[56] | r_down[57]};
    end
  end

  // Registered read data.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_kbd_data <= '0;
    end else begin
      r_kbd_data <= w_sel;
    end
  end

  assign kbd_data  = r_kbd_data;
  assign reset_req = r_reset_req;

endmodule
`default_nettype wire
